// File: rtl/maj3_sweep_checker.sv
// Stimulus-and-check stage for a 3-input majority block: sweeps {A,B,C} through all
// 8 vectors, samples Y after a settle window and records mismatches. Option: MAJ3_STOP_ON_FAIL_EN.
module maj3_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXP_TABLE     = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [7:0] fv_q, fv_d;
  logic [2:0] ff_q, ff_d;

  logic       mismatch;
  logic [3:0] err_next;
  logic [7:0] fv_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    mismatch = (Y != EXP_TABLE[idx_q]);
    err_next = err_q;
    fv_next  = fv_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = '0;
          ff_d    = '0;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end

      SAMPLE: begin
        if (mismatch) begin
          err_next        = err_q + 4'd1;
          fv_next[idx_q]  = 1'b1;
          // err_q still zero means this is the first mismatch of the run
          if (err_q == '0) ff_d = idx_q;
        end
        err_d = err_next;
        fv_d  = fv_next;
`ifdef MAJ3_STOP_ON_FAIL_EN
        if (mismatch || idx_q == 3'd7) begin
`else
        if (idx_q == 3'd7) begin
`endif
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign A          = idx_q[2];
  assign B          = idx_q[1];
  assign C          = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fv_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_maj3_sweep_checker.sv
// Testbench for maj3_sweep_checker: table-driven DUT-response tables, control-case
// sequences and randomized response tables checked against a reference model.
module tb_maj3_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st1 = 1'b0, st3 = 1'b0;
  logic y1, y3;
  logic a1, b1, c1, busy1, done1, pass1;
  logic a3, b3, c3, busy3, done3, pass3;
  logic [3:0] err1, err3;
  logic [7:0] fv1, fv3;
  logic [2:0] ff1, ff3;

  logic [7:0] ytab = 8'hE8;
  bit sel = 1'b0;

  logic r_a, r_b, r_c, r_busy, r_done, r_pass;
  logic [3:0] r_err;
  logic [7:0] r_fv;
  logic [2:0] r_ff;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  maj3_sweep_checker #(.SETTLE_CYCLES(1), .EXP_TABLE(8'hE8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .A(a1), .B(b1), .C(c1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fv1), .first_fail(ff1)
  );

  maj3_sweep_checker #(.SETTLE_CYCLES(3), .EXP_TABLE(8'hE8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .A(a3), .B(b3), .C(c3), .Y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_vec(fv3), .first_fail(ff3)
  );

  // Emulated DUT under test: Y is a lookup of the current stimulus in ytab
  always_comb begin
    y1 = ytab[{a1, b1, c1}];
    y3 = ytab[{a3, b3, c3}];
  end

  always_comb begin
    if (sel) begin
      r_a = a3; r_b = b3; r_c = c3; r_busy = busy3; r_done = done3; r_pass = pass3;
      r_err = err3; r_fv = fv3; r_ff = ff3;
    end else begin
      r_a = a1; r_b = b1; r_c = c1; r_busy = busy1; r_done = done1; r_pass = pass1;
      r_err = err1; r_fv = fv1; r_ff = ff1;
    end
  end

  typedef struct {
    logic [3:0] err;
    logic [7:0] fv;
    logic [2:0] ff;
    logic       pass;
    logic [2:0] abc;
    int         cycles;
  } exp_t;

  typedef struct {
    logic [7:0] yt;
    exp_t       e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) st3 = v;
    else     st1 = v;
  endtask

  // Reference: mismatches are simply the XOR of the response table against majority
  function automatic exp_t model(input logic [7:0] yt, input int s);
    exp_t e;
    logic [7:0] diff;
    bit found;
    diff   = yt ^ 8'hE8;
    e.err  = '0;
    e.ff   = '0;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        e.err = e.err + 4'd1;
        if (!found) begin
          e.ff  = 3'(i);
          found = 1'b1;
        end
      end
    end
    e.fv     = diff;
    e.pass   = (diff == 8'h00);
    e.abc    = 3'd7;
    e.cycles = 8 * (s + 1);
`ifdef MAJ3_STOP_ON_FAIL_EN
    if (found) begin
      e.err    = 4'd1;
      e.fv     = 8'h01 << e.ff;
      e.abc    = e.ff;
      e.cycles = (int'(e.ff) + 1) * (s + 1);
    end
`endif
    return e;
  endfunction

  task automatic run_and_check(input string tag, input bit sl, input int s,
                               input logic [7:0] yt, input int restart_at, input exp_t e);
    int n;
    int budget;
    bit trace_ok;
    sel      = sl;
    ytab     = yt;
    n        = 0;
    trace_ok = 1'b1;
    budget   = 8 * (s + 1) + 20;
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    check({tag, ".busy_on_start"}, 32'(r_busy), 32'd1);
    while (!r_done && n < budget) begin
      if ({r_a, r_b, r_c} != 3'(n / (s + 1))) trace_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
      set_start(n == restart_at);
    end
    set_start(1'b0);
    check({tag, ".cycles"}, 32'(n), 32'(e.cycles));
    check({tag, ".abc_trace"}, 32'(trace_ok), 32'd1);
    check({tag, ".done"}, 32'(r_done), 32'd1);
    check({tag, ".busy"}, 32'(r_busy), 32'd0);
    check({tag, ".pass"}, 32'(r_pass), 32'(e.pass));
    check({tag, ".err_count"}, 32'(r_err), 32'(e.err));
    check({tag, ".fail_vec"}, 32'(r_fv), 32'(e.fv));
    check({tag, ".first_fail"}, 32'(r_ff), 32'(e.ff));
    check({tag, ".abc_final"}, 32'({r_a, r_b, r_c}), 32'(e.abc));
  endtask

  vec_t vt[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    logic [7:0] yt;
    bit sl;

    // {response table, err, fail_vec, first_fail, pass, final ABC, cycles} at SETTLE_CYCLES=1
`ifdef MAJ3_STOP_ON_FAIL_EN
    vt[0] = '{8'hE8, '{4'd0, 8'h00, 3'd0, 1'b1, 3'd7, 16}};
    vt[1] = '{8'h00, '{4'd1, 8'h08, 3'd3, 1'b0, 3'd3, 8}};
    vt[2] = '{8'hFF, '{4'd1, 8'h01, 3'd0, 1'b0, 3'd0, 2}};
    vt[3] = '{8'hF0, '{4'd1, 8'h08, 3'd3, 1'b0, 3'd3, 8}};
`else
    vt[0] = '{8'hE8, '{4'd0, 8'h00, 3'd0, 1'b1, 3'd7, 16}};
    vt[1] = '{8'h00, '{4'd4, 8'hE8, 3'd3, 1'b0, 3'd7, 16}};
    vt[2] = '{8'hFF, '{4'd4, 8'h17, 3'd0, 1'b0, 3'd7, 16}};
    vt[3] = '{8'hF0, '{4'd2, 8'h18, 3'd3, 1'b0, 3'd7, 16}};
`endif

    repeat (3) @(negedge clk);
    check("reset.dut1", 32'({a1, b1, c1, busy1, done1, pass1, err1, fv1, ff1}), 32'd0);
    check("reset.dut3", 32'({a3, b3, c3, busy3, done3, pass3, err3, fv3, ff3}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      run_and_check($sformatf("table%0d", i), 1'b0, 1, vt[i].yt, 0, vt[i].e);

    e = '{4'd0, 8'h00, 3'd0, 1'b1, 3'd7, 32};
    run_and_check("settle3", 1'b1, 3, 8'hE8, 0, e);

    // start re-asserted at cycle 5 of a busy run must be ignored
    run_and_check("restart_busy", 1'b0, 1, 8'hE8, 5, vt[0].e);

    // start held high: DONE results for exactly one cycle, then a fresh run
    sel  = 1'b0;
    ytab = 8'h00;
    e    = model(8'h00, 1);
    @(negedge clk) set_start(1'b1);
    n = 0;
    @(negedge clk);
    while (!r_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("held.done", 32'(r_done), 32'd1);
    check("held.err_in_done", 32'(r_err), 32'(e.err));
    @(negedge clk);
    check("held.next_run", 32'({r_done, r_busy, r_err, r_fv}), 32'({1'b0, 1'b1, 4'd0, 8'h00}));
    set_start(1'b0);
    n = 0;
    while (!r_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("held.second_done", 32'(r_done), 32'd1);

    // reset mid-run clears all outputs immediately
    ytab = 8'h00;
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", 32'({a1, b1, c1, busy1, done1, pass1, err1, fv1, ff1}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_and_check("after_reset", 1'b0, 1, 8'hE8, 0, vt[0].e);

    for (int k = 0; k < 12; k++) begin
      yt = 8'($urandom);
      sl = 1'($urandom);
      e  = model(yt, sl ? 3 : 1);
      run_and_check($sformatf("rand%0d", k), sl, sl ? 3 : 1, yt,
                    int'($urandom_range(0, 6)), e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
